exec_cond_mcycle: RTL and testbench

//  Execute-stage consumer of the D2E control register. Evaluates the ARM condition field against
//  the registered NZCV flags, gates PCS/RegW/MemW/MWrite, updates flags, and runs an iterative
//  32-bit MUL/DIV unit. While that unit is busy it drives Busy, which becomes the pipeline Stall.

---
 rtl/exec_cond_mcycle_pkg.sv | 51 +++++
 rtl/exec_cond_mcycle_mcycle_core.sv | 74 +++++++
 rtl/exec_cond_mcycle.sv | 60 ++++++
 tb/tb_exec_cond_mcycle.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_cond_mcycle_pkg.sv
// exec_cond_mcycle_pkg: condition codes, FSM encoding, flag indices and the condition evaluator
package exec_cond_mcycle_pkg;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic condCheck(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: condCheck = z;
      COND_NE: condCheck = !z;
      COND_CS: condCheck = c;
      COND_CC: condCheck = !c;
      COND_MI: condCheck = n;
      COND_PL: condCheck = !n;
      COND_VS: condCheck = v;
      COND_VC: condCheck = !v;
      COND_HI: condCheck = c && !z;
      COND_LS: condCheck = !c || z;
      COND_GE: condCheck = n == v;
      COND_LT: condCheck = n != v;
      COND_GT: condCheck = !z && (n == v);
      COND_LE: condCheck = z || (n != v);
      COND_AL: condCheck = 1'b1;
      default: condCheck = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/exec_cond_mcycle_mcycle_core.sv
// mcycle_core: iterative unsigned MUL (low half) / DIV (quotient), one step per cycle
module mcycle_core import exec_cond_mcycle_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic             isDiv;
  logic [WIDTH-1:0] acc, accNext;
  logic [WIDTH-1:0] opB, opBNext;
  logic [WIDTH-1:0] opC, opCNext;
  logic [WIDTH:0]   remShift;
  logic             geq;
  logic             lastStep;

  // busy asserts in the start cycle itself so the pipeline stalls immediately
  assign busy     = (state == BUSY) || (state == IDLE && start);
  assign done     = state == DONE;
  assign lastStep = count == CW'(WIDTH - 1);
  assign remShift = {1'b0, acc[WIDTH-1:0]} << 1 | {{WIDTH{1'b0}}, opC[WIDTH-1]};
  assign geq      = remShift >= {1'b0, opB};

  // one shift-add (MUL) or restoring-subtract (DIV) iteration; acc holds the product or remainder
  always_comb begin
    accNext = isDiv ? (geq ? WIDTH'(remShift - {1'b0, opB}) : remShift[WIDTH-1:0])
                    : acc + (opC[0] ? opB : '0);
    opBNext = isDiv ? opB : opB << 1;
    opCNext = isDiv ? {opC[WIDTH-2:0], geq} : opC >> 1;
  end

  // FSM, operand latch, iteration counter and result register
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state  <= IDLE;
      count  <= '0;
      isDiv  <= 1'b0;
      acc    <= '0;
      opB    <= '0;
      opC    <= '0;
      result <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        state <= BUSY;
        count <= '0;
        isDiv <= op;
        acc   <= '0;
        opB   <= op2;
        opC   <= op1;
      end
    end else if (state == BUSY) begin
      acc   <= accNext;
      opB   <= opBNext;
      opC   <= opCNext;
      count <= count + CW'(1);
      if (lastStep) begin
        state  <= DONE;
        result <= isDiv ? opCNext : accNext;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: rtl/exec_cond_mcycle.sv
// exec_cond_mcycle: condition check, NZCV register, write gating and multi-cycle unit wrapper
module exec_cond_mcycle import exec_cond_mcycle_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic [3:0]       CondE,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagWE,
  input  logic             PCSE,
  input  logic             RegWE,
  input  logic             MemWE,
  input  logic             NoWriteE,
  input  logic             Carry_useE,
  input  logic             M_StartE,
  input  logic             MCycleOpE,
  input  logic             MWriteE,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic             PCSrcE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             MWriteOutE,
  output logic             CarryIn,
  output logic             Busy,
  output logic             MDone,
  output logic [WIDTH-1:0] MResult
);
  logic [3:0] flags;
  logic       condEx;

  assign condEx     = condCheck(CondE, flags);
  assign PCSrcE     = PCSE & condEx & ~Busy;
  assign RegWriteE  = RegWE & condEx & ~NoWriteE & ~Busy;
  assign MemWriteE  = MemWE & condEx & ~Busy;
  assign MWriteOutE = MWriteE & condEx & ~Busy;
  assign CarryIn    = Carry_useE & flags[FLAG_C];

  // NZCV register: split N,Z / C,V write enables, frozen while stalled or condition fails
  always_ff @(posedge clk) begin
    if (rst_p) begin
      flags <= '0;
    end else if (condEx && !Busy) begin
      if (FlagWE[1]) {flags[FLAG_N], flags[FLAG_Z]} <= {ALUFlags[FLAG_N], ALUFlags[FLAG_Z]};
      if (FlagWE[0]) {flags[FLAG_C], flags[FLAG_V]} <= {ALUFlags[FLAG_C], ALUFlags[FLAG_V]};
    end
  end

  mcycle_core #(.WIDTH(WIDTH)) core (
    .clk    (clk),
    .rst_p  (rst_p),
    .start  (M_StartE & condEx),
    .op     (MCycleOpE),
    .op1    (Operand1),
    .op2    (Operand2),
    .busy   (Busy),
    .done   (MDone),
    .result (MResult)
  );
endmodule

// File: tb/tb_exec_cond_mcycle.sv
// tb_exec_cond_mcycle: directed self-checking bench for exec_cond_mcycle
module tb_exec_cond_mcycle;
  logic        clk = 1'b0;
  logic        rst_p;
  logic [3:0]  CondE, ALUFlags;
  logic [1:0]  FlagWE;
  logic        PCSE, RegWE, MemWE, NoWriteE, Carry_useE, M_StartE, MCycleOpE, MWriteE;
  logic [31:0] Operand1, Operand2;
  logic        PCSrcE, RegWriteE, MemWriteE, MWriteOutE, CarryIn, Busy, MDone;
  logic [31:0] MResult;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastRes;

  exec_cond_mcycle #(.WIDTH(32)) dut (
    .clk(clk), .rst_p(rst_p), .CondE(CondE), .ALUFlags(ALUFlags), .FlagWE(FlagWE),
    .PCSE(PCSE), .RegWE(RegWE), .MemWE(MemWE), .NoWriteE(NoWriteE), .Carry_useE(Carry_useE),
    .M_StartE(M_StartE), .MCycleOpE(MCycleOpE), .MWriteE(MWriteE),
    .Operand1(Operand1), .Operand2(Operand2),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MWriteOutE(MWriteOutE),
    .CarryIn(CarryIn), .Busy(Busy), .MDone(MDone), .MResult(MResult)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleIn();
    CondE = 4'b1110; ALUFlags = 4'b0000; FlagWE = 2'b00;
    PCSE = 0; RegWE = 0; MemWE = 0; NoWriteE = 0; Carry_useE = 0;
    M_StartE = 0; MCycleOpE = 0; MWriteE = 0; Operand1 = 0; Operand2 = 0;
  endtask

  // reads N,Z,C,V back through MI/EQ/CS/VS conditions on RegWriteE
  task automatic probeFlags(output logic [3:0] f);
    FlagWE = 2'b00; M_StartE = 0; NoWriteE = 0; RegWE = 1;
    CondE = 4'b0100; #1 f[3] = RegWriteE;
    CondE = 4'b0000; #1 f[2] = RegWriteE;
    CondE = 4'b0010; #1 f[1] = RegWriteE;
    CondE = 4'b0110; #1 f[0] = RegWriteE;
    RegWE = 0; CondE = 4'b1110;
  endtask

  task automatic condSweep(output logic [15:0] v);
    FlagWE = 2'b00; M_StartE = 0; NoWriteE = 0; RegWE = 1;
    for (int i = 0; i < 16; i++) begin
      CondE = 4'(i);
      #1 v[i] = RegWriteE;
    end
    RegWE = 0; CondE = 4'b1110;
  endtask

  task automatic runOp(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic scramble, output logic [31:0] res, output int n);
    tick();
    idleIn();
    MCycleOpE = op; Operand1 = a; Operand2 = b; M_StartE = 1;
    n = 0;
    while (!MDone && n < 40) begin
      tick();
      n++;
      M_StartE = 0;
      if (scramble) begin
        Operand1 = $urandom;
        Operand2 = $urandom;
      end
    end
    res = MResult;
    tick();
    idleIn();
  endtask

  task automatic test_reset();
    logic [3:0] f;
    idleIn();
    rst_p = 1;
    tick();
    tick();
    rst_p = 0;
    #1;
    checks++;
    if ({Busy, MDone, MResult} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b res=%h expected 0 0 0", Busy, MDone, MResult);
    end
    probeFlags(f);
    checks++;
    if (f !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", f); end
    Carry_useE = 1;
    #1;
    checks++;
    if (CarryIn !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", CarryIn); end
    Carry_useE = 0;
  endtask

  task automatic test_flags();
    logic [15:0] v;
    tick();
    idleIn();
    FlagWE = 2'b11; ALUFlags = 4'b0100;
    tick();
    FlagWE = 2'b00; CondE = 4'b0000; RegWE = 1;
    #1;
    checks++;
    if (RegWriteE !== 1'b1) begin errors++; $display("FAIL flags_eq: got %b expected 1", RegWriteE); end
    CondE = 4'b0001; PCSE = 1; MemWE = 1; MWriteE = 1;
    #1;
    checks++;
    if ({PCSrcE, RegWriteE, MemWriteE, MWriteOutE} !== 4'b0000) begin
      errors++;
      $display("FAIL flags_ne: got %b expected 0000", {PCSrcE, RegWriteE, MemWriteE, MWriteOutE});
    end
    CondE = 4'b0000; NoWriteE = 1;
    #1;
    checks++;
    if ({PCSrcE, RegWriteE, MemWriteE, MWriteOutE} !== 4'b1011) begin
      errors++;
      $display("FAIL flags_nowrite: got %b expected 1011", {PCSrcE, RegWriteE, MemWriteE, MWriteOutE});
    end
    idleIn();
    condSweep(v);
    checks++;
    if (v !== 16'h66A9) begin errors++; $display("FAIL cond_table_0100: got %h expected 66a9", v); end
  endtask

  task automatic test_partial();
    logic [3:0]  f;
    logic [15:0] v;
    tick();
    idleIn();
    FlagWE = 2'b11; ALUFlags = 4'b1111;
    tick();
    FlagWE = 2'b10; ALUFlags = 4'b0000;
    tick();
    probeFlags(f);
    checks++;
    if (f !== 4'b0011) begin errors++; $display("FAIL partial_flags: got %b expected 0011", f); end
    condSweep(v);
    checks++;
    if (v !== 16'h6966) begin errors++; $display("FAIL cond_table_0011: got %h expected 6966", v); end
    tick();
    idleIn();
    Carry_useE = 1;
    #1;
    checks++;
    if (CarryIn !== 1'b1) begin errors++; $display("FAIL carry_in: got %b expected 1", CarryIn); end
    Carry_useE = 0;
    #1;
    checks++;
    if (CarryIn !== 1'b0) begin errors++; $display("FAIL carry_unused: got %b expected 0", CarryIn); end
    Carry_useE = 1; FlagWE = 2'b01; ALUFlags = 4'b0000;
    #1;
    checks++;
    if (CarryIn !== 1'b1) begin errors++; $display("FAIL carry_same_cycle: got %b expected 1", CarryIn); end
    tick();
    FlagWE = 2'b00;
    #1;
    checks++;
    if (CarryIn !== 1'b0) begin errors++; $display("FAIL carry_next_cycle: got %b expected 0", CarryIn); end
    Carry_useE = 0;
  endtask

  task automatic test_mul();
    logic [3:0] f;
    int         bad;
    tick();
    idleIn();
    Operand1 = 32'd7; Operand2 = 32'd6; M_StartE = 1;
    RegWE = 1; PCSE = 1; MemWE = 1; MWriteE = 1;
    #1;
    checks++;
    if (Busy !== 1'b1 || {PCSrcE, RegWriteE, MemWriteE, MWriteOutE} !== 4'b0000) begin
      errors++;
      $display("FAIL mul_start: got busy=%b gates=%b expected 1 0000", Busy,
               {PCSrcE, RegWriteE, MemWriteE, MWriteOutE});
    end
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      M_StartE = 0;
      FlagWE = 2'b11; ALUFlags = 4'b1111;
      Operand1 = 32'd9; Operand2 = 32'd9;
      #1;
      if (Busy !== 1'b1 || MDone !== 1'b0 || RegWriteE !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mul_busy_window: got %0d bad cycles expected 0", bad); end
    tick();
    FlagWE = 2'b00;
    #1;
    checks++;
    if (Busy !== 1'b0 || MDone !== 1'b1 || MResult !== 32'd42) begin
      errors++;
      $display("FAIL mul_done: got busy=%b done=%b res=%0d expected 0 1 42", Busy, MDone, MResult);
    end
    checks++;
    if ({PCSrcE, RegWriteE, MemWriteE, MWriteOutE} !== 4'b1111) begin
      errors++;
      $display("FAIL mul_release: got %b expected 1111", {PCSrcE, RegWriteE, MemWriteE, MWriteOutE});
    end
    M_StartE = 1;
    #1;
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL done_ignores_start: got busy=%b expected 0", Busy); end
    tick();
    M_StartE = 0;
    #1;
    checks++;
    if (Busy !== 1'b0 || MDone !== 1'b0 || MResult !== 32'd42) begin
      errors++;
      $display("FAIL mul_idle_hold: got busy=%b done=%b res=%0d expected 0 0 42", Busy, MDone, MResult);
    end
    idleIn();
    probeFlags(f);
    checks++;
    if (f !== 4'b0000) begin errors++; $display("FAIL flags_frozen_busy: got %b expected 0000", f); end
  endtask

  task automatic test_div();
    logic [31:0] r;
    int          n;
    runOp(1'b1, 32'd100, 32'd7, 1'b1, r, n);
    checks++;
    if (r !== 32'd14 || n != 33) begin
      errors++;
      $display("FAIL div_100_7: got %0d after %0d cycles expected 14 after 33", r, n);
    end
    runOp(1'b1, 32'd5, 32'd0, 1'b0, r, n);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by_zero: got %h expected ffffffff", r); end
    runOp(1'b1, 32'd1000, 32'd1001, 1'b0, r, n);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL div_small: got %h expected 0", r); end
    runOp(1'b1, 32'hFFFF_FFFF, 32'h10, 1'b0, r, n);
    checks++;
    if (r !== 32'h0FFF_FFFF) begin errors++; $display("FAIL div_max: got %h expected 0fffffff", r); end
    runOp(1'b1, 32'hF000_0000, 32'hC000_0000, 1'b0, r, n);
    checks++;
    if (r !== 32'd1) begin errors++; $display("FAIL div_large_divisor: got %h expected 1", r); end
  endtask

  task automatic test_mul_edge();
    logic [31:0] r;
    int          n;
    runOp(1'b0, 32'h12345, 32'd0, 1'b0, r, n);
    checks++;
    if (r !== 32'd0 || n != 33) begin
      errors++;
      $display("FAIL mul_by_zero: got %h after %0d cycles expected 0 after 33", r, n);
    end
    runOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, n);
    checks++;
    if (r !== 32'd1) begin errors++; $display("FAIL mul_max: got %h expected 1", r); end
    runOp(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0, r, n);
    checks++;
    if (r !== 32'd0) begin errors++; $display("FAIL mul_trunc: got %h expected 0", r); end
    runOp(1'b0, 32'h1234_5678, 32'd3, 1'b1, r, n);
    checks++;
    if (r !== 32'h369D_0368) begin errors++; $display("FAIL mul_scramble: got %h expected 369d0368", r); end
    lastRes = 32'h369D_0368;
  endtask

  task automatic test_cond_fail();
    logic [3:0] f;
    int         bad;
    tick();
    idleIn();
    FlagWE = 2'b11; ALUFlags = 4'b0000;
    tick();
    FlagWE = 2'b00; CondE = 4'b0000; M_StartE = 1; Operand1 = 32'd3; Operand2 = 32'd3;
    #1;
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL cond_fail_start: got busy=%b expected 0", Busy); end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (Busy !== 1'b0 || MDone !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || MResult !== lastRes) begin
      errors++;
      $display("FAIL cond_fail_idle: got %0d bad cycles res=%h expected 0 and %h", bad, MResult, lastRes);
    end
    M_StartE = 0; FlagWE = 2'b11; ALUFlags = 4'b1111;
    tick();
    probeFlags(f);
    checks++;
    if (f !== 4'b0000) begin errors++; $display("FAIL cond_fail_flags: got %b expected 0000", f); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] f;
    int         dones;
    tick();
    idleIn();
    FlagWE = 2'b11; ALUFlags = 4'b1111;
    tick();
    FlagWE = 2'b00; Operand1 = 32'd3; Operand2 = 32'd5; M_StartE = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      M_StartE = 0;
    end
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got busy=%b expected 1", Busy); end
    rst_p = 1;
    tick();
    rst_p = 0;
    idleIn();
    #1;
    checks++;
    if (Busy !== 1'b0 || MDone !== 1'b0 || MResult !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b done=%b res=%h expected 0 0 0", Busy, MDone, MResult);
    end
    probeFlags(f);
    checks++;
    if (f !== 4'b0000) begin errors++; $display("FAIL mid_reset_flags: got %b expected 0000", f); end
    dones = 0;
    for (int i = 0; i < 36; i++) begin
      tick();
      if (MDone === 1'b1 || Busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL mid_reset_abort: got %0d active cycles expected 0", dones); end
  endtask

  initial begin
    idleIn();
    rst_p = 1;
    lastRes = 32'd0;
    test_reset();
    test_flags();
    test_partial();
    test_mul();
    test_div();
    test_mul_edge();
    test_cond_fail();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
